// File: rtl/spec_switch_allocator_rr_if.sv
// Request/grant bundle for spec_switch_allocator_rr; kill_cnt_o exists only when SPEC_KILL_CNT_EN is defined.
interface spec_switch_allocator_rr_if #(
    parameter int PORT_NUM  = 5,
    parameter int VC_NUM    = 2,
    parameter int PORT_SIZE = $clog2(PORT_NUM)
);
    logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] out_port_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0]                nonspec_request_i;
    logic [PORT_NUM-1:0][VC_NUM-1:0]                spec_request_i;
    logic [PORT_NUM-1:0]                            out_ready_i;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]              grants_o;
    logic [PORT_NUM-1:0][VC_NUM-1:0]                granted_vc_o;
    logic [PORT_NUM-1:0]                            spec_grant_o;
`ifdef SPEC_KILL_CNT_EN
    logic [15:0]                                    kill_cnt_o;
`endif

    modport master (
        output out_port_i, nonspec_request_i, spec_request_i, out_ready_i,
`ifdef SPEC_KILL_CNT_EN
        input  kill_cnt_o,
`endif
        input  grants_o, granted_vc_o, spec_grant_o
    );

    modport slave (
        input  out_port_i, nonspec_request_i, spec_request_i, out_ready_i,
`ifdef SPEC_KILL_CNT_EN
        output kill_cnt_o,
`endif
        output grants_o, granted_vc_o, spec_grant_o
    );
endinterface

// File: rtl/spec_switch_allocator_rr.sv
// Speculative separable input-first switch allocator with round-robin VC and input-port pointers.
// Define SPEC_KILL_CNT_EN to add a saturating counter of speculative winners killed by the merge.
module spec_switch_allocator_rr #(
    parameter int PORT_NUM  = 5,
    parameter int VC_NUM    = 2,
    parameter int PORT_SIZE = $clog2(PORT_NUM)
) (
    input logic clk,
    input logic rst,
    spec_switch_allocator_rr_if.slave sa
);
    localparam int VC_SIZE = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef logic [PORT_SIZE-1:0] port_t;
    typedef logic [VC_SIZE-1:0]   vc_t;

    // Returns {valid, index} of the first request at or circularly above ptr.
    function automatic logic [VC_SIZE:0] pick_vc(input logic [VC_NUM-1:0] req, input vc_t ptr);
        logic [VC_SIZE:0] res;
        int idx;
        res = '0;
        for (int k = 0; k < VC_NUM; k++) begin
            idx = int'(ptr) + k;
            if (idx >= VC_NUM) idx = idx - VC_NUM;
            if (!res[VC_SIZE] && req[idx]) res = {1'b1, vc_t'(idx)};
        end
        return res;
    endfunction

    function automatic logic [PORT_SIZE:0] pick_port(input logic [PORT_NUM-1:0] req, input port_t ptr);
        logic [PORT_SIZE:0] res;
        int idx;
        res = '0;
        for (int k = 0; k < PORT_NUM; k++) begin
            idx = int'(ptr) + k;
            if (idx >= PORT_NUM) idx = idx - PORT_NUM;
            if (!res[PORT_SIZE] && req[idx]) res = {1'b1, port_t'(idx)};
        end
        return res;
    endfunction

    function automatic vc_t next_vc(input vc_t cur);
        return (int'(cur) == VC_NUM - 1) ? '0 : cur + 1'b1;
    endfunction

    function automatic port_t next_port(input port_t cur);
        return (int'(cur) == PORT_NUM - 1) ? '0 : cur + 1'b1;
    endfunction

    vc_t   [PORT_NUM-1:0] ptr_in_ns, ptr_in_sp;
    port_t [PORT_NUM-1:0] ptr_out_ns, ptr_out_sp;

    logic [PORT_NUM-1:0][PORT_NUM-1:0] grants_q;
    logic [PORT_NUM-1:0][VC_NUM-1:0]   vc_q;
    logic [PORT_NUM-1:0]               spec_q;

    logic [PORT_NUM-1:0][VC_NUM-1:0]   elig_ns, elig_sp;
    logic [PORT_NUM-1:0]               in_ns_vld, in_sp_vld;
    vc_t   [PORT_NUM-1:0]              in_ns_vc, in_sp_vc;
    port_t [PORT_NUM-1:0]              in_ns_dst, in_sp_dst;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] req_ns, req_sp;      // [output][input]
    logic [PORT_NUM-1:0]               out_ns_vld, out_sp_vld;
    port_t [PORT_NUM-1:0]              out_ns_win, out_sp_win;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] ns_grant, sp_grant;  // [input][output]
    logic [PORT_NUM-1:0]               row_ns, col_ns, row_sp, col_sp;
    logic [PORT_NUM-1:0][PORT_NUM-1:0] sp_keep, grants_d;
    logic [PORT_NUM-1:0][VC_NUM-1:0]   vc_d;

    // Out-of-range destinations and ports without credit never enter arbitration.
    always_comb begin
        elig_ns = '0;
        elig_sp = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (int'(sa.out_port_i[p][v]) < PORT_NUM) begin
                    if (sa.out_ready_i[sa.out_port_i[p][v]]) begin
                        elig_ns[p][v] = sa.nonspec_request_i[p][v];
                        elig_sp[p][v] = sa.spec_request_i[p][v] & ~sa.nonspec_request_i[p][v];
                    end
                end
            end
        end
    end

    always_comb begin
        in_ns_vld = '0;
        in_sp_vld = '0;
        in_ns_vc  = '0;
        in_sp_vc  = '0;
        in_ns_dst = '0;
        in_sp_dst = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            {in_ns_vld[p], in_ns_vc[p]} = pick_vc(elig_ns[p], ptr_in_ns[p]);
            {in_sp_vld[p], in_sp_vc[p]} = pick_vc(elig_sp[p], ptr_in_sp[p]);
            in_ns_dst[p] = sa.out_port_i[p][in_ns_vc[p]];
            in_sp_dst[p] = sa.out_port_i[p][in_sp_vc[p]];
        end
    end

    always_comb begin
        req_ns = '0;
        req_sp = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                req_ns[o][p] = in_ns_vld[p] && (in_ns_dst[p] == port_t'(o));
                req_sp[o][p] = in_sp_vld[p] && (in_sp_dst[p] == port_t'(o));
            end
        end
    end

    always_comb begin
        out_ns_vld = '0;
        out_sp_vld = '0;
        out_ns_win = '0;
        out_sp_win = '0;
        ns_grant   = '0;
        sp_grant   = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            {out_ns_vld[o], out_ns_win[o]} = pick_port(req_ns[o], ptr_out_ns[o]);
            {out_sp_vld[o], out_sp_win[o]} = pick_port(req_sp[o], ptr_out_sp[o]);
            if (out_ns_vld[o]) ns_grant[out_ns_win[o]][o] = 1'b1;
            if (out_sp_vld[o]) sp_grant[out_sp_win[o]][o] = 1'b1;
        end
    end

    // A speculative grant survives only where neither its row nor its column carries a non-speculative one.
    always_comb begin
        row_ns  = '0;
        col_ns  = '0;
        row_sp  = '0;
        col_sp  = '0;
        sp_keep = '0;
        vc_d    = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                row_ns[p] = row_ns[p] | ns_grant[p][o];
                col_ns[o] = col_ns[o] | ns_grant[p][o];
            end
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                sp_keep[p][o] = sp_grant[p][o] & ~row_ns[p] & ~col_ns[o];
                row_sp[p]     = row_sp[p] | sp_keep[p][o];
                col_sp[o]     = col_sp[o] | sp_keep[p][o];
            end
        end
        grants_d = ns_grant | sp_keep;
        for (int p = 0; p < PORT_NUM; p++) begin
            if (row_ns[p])      vc_d[p][in_ns_vc[p]] = 1'b1;
            else if (row_sp[p]) vc_d[p][in_sp_vc[p]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grants_q   <= '0;
            vc_q       <= '0;
            spec_q     <= '0;
            ptr_in_ns  <= '0;
            ptr_in_sp  <= '0;
            ptr_out_ns <= '0;
            ptr_out_sp <= '0;
        end else begin
            grants_q <= grants_d;
            vc_q     <= vc_d;
            spec_q   <= row_sp;
            for (int p = 0; p < PORT_NUM; p++) begin
                if (row_ns[p]) ptr_in_ns[p] <= next_vc(in_ns_vc[p]);
                if (row_sp[p]) ptr_in_sp[p] <= next_vc(in_sp_vc[p]);
            end
            for (int o = 0; o < PORT_NUM; o++) begin
                if (out_ns_vld[o]) ptr_out_ns[o] <= next_port(out_ns_win[o]);
                if (col_sp[o])     ptr_out_sp[o] <= next_port(out_sp_win[o]);
            end
        end
    end

    assign sa.grants_o     = grants_q;
    assign sa.granted_vc_o = vc_q;
    assign sa.spec_grant_o = spec_q;

`ifdef SPEC_KILL_CNT_EN
    logic [15:0] kill_cnt, kill_add;
    logic [16:0] kill_sum;

    always_comb begin
        kill_add = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                if (sp_grant[p][o] && !sp_keep[p][o]) kill_add = kill_add + 16'd1;
            end
        end
        kill_sum = {1'b0, kill_cnt} + {1'b0, kill_add};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) kill_cnt <= '0;
        else      kill_cnt <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
    end

    assign sa.kill_cnt_o = kill_cnt;
`endif

endmodule

// File: tb/tb_spec_switch_allocator_rr.sv
// Randomized and directed bench for spec_switch_allocator_rr against a distance-based round-robin model.
module tb_spec_switch_allocator_rr;
    localparam int P  = 5;
    localparam int V  = 2;
    localparam int PS = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spec_switch_allocator_rr_if #(.PORT_NUM(P), .VC_NUM(V), .PORT_SIZE(PS)) sa ();

    spec_switch_allocator_rr #(.PORT_NUM(P), .VC_NUM(V), .PORT_SIZE(PS)) dut (
        .clk (clk),
        .rst (rst),
        .sa  (sa)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: each pointer is the index holding top priority.
    int m_in_ns[P], m_in_sp[P], m_out_ns[P], m_out_sp[P];
    int m_kill;
    logic [P-1:0][P-1:0] exp_g;
    logic [P-1:0][V-1:0] exp_vc;
    logic [P-1:0]        exp_sg;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < P; i++) begin
            m_in_ns[i] = 0; m_in_sp[i] = 0; m_out_ns[i] = 0; m_out_sp[i] = 0;
        end
        m_kill = 0;
        exp_g  = '0; exp_vc = '0; exp_sg = '0;
    endtask

    // Winner = requester with the smallest circular distance from the pointer.
    task automatic model_step();
        int ns_vc[P], sp_vc[P], ns_dst[P], sp_dst[P], ns_win[P], sp_win[P];
        int dn, ds, d, dst, kills, p;
        bit ns_row[P], ns_col[P];
        kills = 0;
        for (int i = 0; i < P; i++) begin
            ns_vc[i] = -1; sp_vc[i] = -1; ns_dst[i] = 0; sp_dst[i] = 0;
            ns_row[i] = 0; ns_col[i] = 0;
            dn = V; ds = V;
            for (int v = 0; v < V; v++) begin
                dst = int'(sa.out_port_i[i][v]);
                if (dst < P) begin
                    if (sa.out_ready_i[dst]) begin
                        d = (v - m_in_ns[i] + V) % V;
                        if (sa.nonspec_request_i[i][v] && d < dn) begin
                            dn = d; ns_vc[i] = v; ns_dst[i] = dst;
                        end
                        d = (v - m_in_sp[i] + V) % V;
                        if (sa.spec_request_i[i][v] && !sa.nonspec_request_i[i][v] && d < ds) begin
                            ds = d; sp_vc[i] = v; sp_dst[i] = dst;
                        end
                    end
                end
            end
        end
        for (int o = 0; o < P; o++) begin
            ns_win[o] = -1; sp_win[o] = -1; dn = P; ds = P;
            for (int i = 0; i < P; i++) begin
                d = (i - m_out_ns[o] + P) % P;
                if (ns_vc[i] >= 0 && ns_dst[i] == o && d < dn) begin dn = d; ns_win[o] = i; end
                d = (i - m_out_sp[o] + P) % P;
                if (sp_vc[i] >= 0 && sp_dst[i] == o && d < ds) begin ds = d; sp_win[o] = i; end
            end
        end
        exp_g = '0; exp_vc = '0; exp_sg = '0;
        for (int o = 0; o < P; o++) begin
            if (ns_win[o] >= 0) begin
                p = ns_win[o];
                exp_g[p][o] = 1'b1;
                exp_vc[p][ns_vc[p]] = 1'b1;
                ns_row[p] = 1; ns_col[o] = 1;
                m_in_ns[p] = (ns_vc[p] + 1) % V;
                m_out_ns[o] = (p + 1) % P;
            end
        end
        for (int o = 0; o < P; o++) begin
            if (sp_win[o] >= 0) begin
                p = sp_win[o];
                if (!ns_row[p] && !ns_col[o]) begin
                    exp_g[p][o] = 1'b1;
                    exp_vc[p][sp_vc[p]] = 1'b1;
                    exp_sg[p] = 1'b1;
                    m_in_sp[p] = (sp_vc[p] + 1) % V;
                    m_out_sp[o] = (p + 1) % P;
                end else begin
                    kills++;
                end
            end
        end
        m_kill = (m_kill + kills > 65535) ? 65535 : m_kill + kills;
    endtask

    function automatic bit inv_ok();
        int c;
        for (int p = 0; p < P; p++) begin
            if ($countones(sa.grants_o[p]) > 1) return 0;
            if ((sa.grants_o[p] != '0) != ($countones(sa.granted_vc_o[p]) == 1)) return 0;
            if (sa.granted_vc_o[p] != '0 && sa.grants_o[p] == '0) return 0;
            if (sa.spec_grant_o[p] && sa.grants_o[p] == '0) return 0;
        end
        for (int o = 0; o < P; o++) begin
            c = 0;
            for (int p = 0; p < P; p++) c += int'(sa.grants_o[p][o]);
            if (c > 1) return 0;
        end
        return 1;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, "_grants"}, sa.grants_o, exp_g);
        chk({tag, "_vc"}, sa.granted_vc_o, exp_vc);
        chk({tag, "_spec"}, sa.spec_grant_o, exp_sg);
`ifdef SPEC_KILL_CNT_EN
        chk({tag, "_kill"}, sa.kill_cnt_o, m_kill);
`endif
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        chk({tag, "_inv"}, inv_ok(), 1);
    endtask

    task automatic clear_in();
        sa.out_port_i        = '0;
        sa.nonspec_request_i = '0;
        sa.spec_request_i    = '0;
        sa.out_ready_i       = '1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        int fair_win[6] = '{0, 1, 4, 0, 1, 4};
        int kill_before;
        logic [P-1:0][P-1:0] m;

        model_reset();
        clear_in();
        sa.nonspec_request_i = '1;
        sa.spec_request_i    = '1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");

        // First grant after release.
        rst = 1'b1;
        clear_in();
        sa.nonspec_request_i[0] = 2'b01;
        sa.out_port_i[0][0]     = 3'd3;
        cycle("first");
        chk("first_row0", sa.grants_o[0], 5'b01000);
        chk("first_vc0", sa.granted_vc_o[0], 2'b01);
        chk("first_spec", sa.spec_grant_o, 0);

        clear_in();
        cycle("idle");
        chk("idle_grants", sa.grants_o, 0);

        // Speculative grant killed by a non-speculative one on the same output.
        clear_in();
        sa.nonspec_request_i[0][0] = 1'b1; sa.out_port_i[0][0] = 3'd2;
        sa.spec_request_i[1][1]    = 1'b1; sa.out_port_i[1][1] = 3'd2;
        kill_before = m_kill;
        cycle("kill");
        chk("kill_row0", sa.grants_o[0], 5'b00100);
        chk("kill_row1", sa.grants_o[1], 0);
`ifdef SPEC_KILL_CNT_EN
        chk("kill_inc", sa.kill_cnt_o, kill_before + 1);
`endif

        clear_in();
        sa.nonspec_request_i[0][0] = 1'b1; sa.out_port_i[0][0] = 3'd1;
        sa.nonspec_request_i[1][0] = 1'b1; sa.out_port_i[1][0] = 3'd1;
        sa.nonspec_request_i[4][0] = 1'b1; sa.out_port_i[4][0] = 3'd1;
        for (int i = 0; i < 6; i++) begin
            cycle("fair");
            m = '0;
            m[fair_win[i]][1] = 1'b1;
            chk("fair_winner", sa.grants_o, m);
        end

        clear_in();
        sa.out_ready_i = 5'b10111;
        sa.nonspec_request_i[2][1] = 1'b1; sa.out_port_i[2][1] = 3'd3;
        cycle("credit_lo");
        chk("credit_lo_grants", sa.grants_o, 0);
        sa.out_ready_i = '1;
        cycle("credit_hi");
        chk("credit_hi_row2", sa.grants_o[2], 5'b01000);
        chk("credit_hi_vc2", sa.granted_vc_o[2], 2'b10);

        clear_in();
        sa.nonspec_request_i[3][0] = 1'b1;
        sa.spec_request_i[3][0]    = 1'b1;
        sa.out_port_i[3][0]        = 3'd0;
        cycle("samevc");
        chk("samevc_row3", sa.grants_o[3], 5'b00001);
        chk("samevc_spec3", sa.spec_grant_o[3], 0);

        clear_in();
        sa.spec_request_i[1][0] = 1'b1; sa.out_port_i[1][0] = 3'd4;
        cycle("speconly");
        chk("speconly_row1", sa.grants_o[1], 5'b10000);
        chk("speconly_spec1", sa.spec_grant_o[1], 1);

        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < P; p++) begin
                sa.out_ready_i[p] = ($urandom_range(0, 4) != 0);
                for (int v = 0; v < V; v++) begin
                    sa.out_port_i[p][v]        = PS'($urandom_range(0, 6));
                    sa.nonspec_request_i[p][v] = ($urandom_range(0, 3) == 0);
                    sa.spec_request_i[p][v]    = ($urandom_range(0, 2) == 0);
                end
            end
            cycle("rand");
        end

        // Asynchronous reset in the middle of contention.
        clear_in();
        for (int p = 0; p < 4; p++) begin
            sa.nonspec_request_i[p][0] = 1'b1;
            sa.out_port_i[p][0]        = 3'd2;
            sa.spec_request_i[p][1]    = 1'b1;
            sa.out_port_i[p][1]        = PS'(p);
        end
        repeat (3) cycle("contend");
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("hold_rst");
        rst = 1'b1;
        cycle("restart");
        m = '0;
        m[0][2] = 1'b1;
        chk("restart_port0", sa.grants_o[0], 5'b00100);
        repeat (4) cycle("restart_more");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
